taxi_fare_core: RTL and testbench

//  Parametrised taximeter core. One clock domain: all divided rates are one-cycle enables, not derived clocks.

---
 rtl/taxi_fare_core.sv | 234 +++++++++++++++++++++++
 tb/tb_taxi_fare_core.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_fare_core.sv
// Taximeter core: metering FSM, fare calculation, sequential BCD conversion and
// a multiplexed 7-segment display driver, all in the clk_50MHz domain.
module taxi_fare_core #(
  parameter int unsigned CNT_W          = 17,
  parameter int unsigned DIGITS         = 5,
  parameter int unsigned SPEED_W        = 4,
  parameter int unsigned TICK_DIV       = 50_000_000,
  parameter int unsigned SCAN_DIV       = 125_000,
  parameter int unsigned START_FARE     = 30,
  parameter int unsigned START_UNITS    = 10,
  parameter int unsigned DEF_UNIT_PRICE = 7
) (
  input  logic               clk_50MHz,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               leap,
  input  logic [SPEED_W-1:0] speed,
  input  logic               cfg_req,
  input  logic [3:0]         cfg_price,
  input  logic [1:0]         disp_sel,
  output logic [CNT_W-1:0]   fare,
  output logic [1:0]         state_o,
  output logic               tick_o,
  output logic               power_on,
  output logic               pricing_mode,
  output logic [DIGITS-1:0]  sm_wei,
  output logic [7:0]         sm_duan
);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, CONFIG = 2'b11} state_t;

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BIT_W  = $clog2(CNT_W + 1);
  localparam int unsigned INC_W  = CNT_W + 1;
  localparam int unsigned FW     = CNT_W + 6;
  localparam int unsigned BCD_W  = 4 * DIGITS;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0]      DISP_MAX = pow10(DIGITS) - 64'd1;
  localparam logic [BCD_W-1:0] NINES    = {DIGITS{4'h9}};

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  state_t             state_q;
  logic [CNT_W-1:0]   dist_q, wait_q, fare_q;
  logic [3:0]         price_q;
  logic [TICK_W-1:0]  tick_cnt_q;
  logic               tick_q;

  // Free-running metering tick: one-cycle enable every TICK_DIV cycles.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else if (tick_cnt_q == TICK_W'(TICK_DIV - 1)) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b1;
    end else begin
      tick_cnt_q <= tick_cnt_q + 1'b1;
      tick_q     <= 1'b0;
    end
  end

  logic [SPEED_W:0]   step;
  logic [CNT_W:0]     dist_sum, wait_sum, u_sum;
  logic [CNT_W-1:0]   dist_inc, wait_inc, fare_calc;
  logic [FW-1:0]      fare_w;

  // Saturating increments and the fare formula for the current counter values.
  always_comb begin
    step     = leap ? {speed, 1'b0} : {1'b0, speed};
    dist_sum = {1'b0, dist_q} + INC_W'(step);
    wait_sum = {1'b0, wait_q} + (leap ? INC_W'(2) : INC_W'(1));
    dist_inc = dist_sum[CNT_W] ? '1 : dist_sum[CNT_W-1:0];
    wait_inc = wait_sum[CNT_W] ? '1 : wait_sum[CNT_W-1:0];
    u_sum    = {1'b0, dist_q} + {1'b0, wait_q};
    if (u_sum <= INC_W'(START_UNITS))
      fare_w = FW'(START_FARE);
    else
      fare_w = FW'(START_FARE) + FW'(u_sum - INC_W'(START_UNITS)) * FW'(price_q);
    fare_calc = (|fare_w[FW-1:CNT_W]) ? '1 : fare_w[CNT_W-1:0];
  end

  // Trip FSM with metering counters, registered fare and unit price.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state_q <= IDLE;
      dist_q  <= '0;
      wait_q  <= '0;
      fare_q  <= '0;
      price_q <= 4'(DEF_UNIT_PRICE);
    end else begin
      case (state_q)
        IDLE: begin
          dist_q <= '0;
          wait_q <= '0;
          if (start) begin
            state_q <= RUN;
            fare_q  <= CNT_W'(START_FARE);
          end else begin
            fare_q <= '0;
            if (cfg_req) state_q <= CONFIG;
          end
        end
        RUN: begin
          fare_q <= fare_calc;
          if (!start)     state_q <= IDLE;
          else if (pause) state_q <= PAUSE;
          else if (tick_q) begin
            if (speed != '0) dist_q <= dist_inc;
            else             wait_q <= wait_inc;
          end
        end
        PAUSE: begin
          fare_q <= fare_calc;
          if (!start)      state_q <= IDLE;
          else if (!pause) state_q <= RUN;
        end
        default: begin
          fare_q <= '0;
          if (cfg_req) begin
            state_q <= IDLE;
            if (cfg_price != 4'd0) price_q <= cfg_price;
          end
        end
      endcase
    end
  end

  logic [CNT_W-1:0] val_sel, lat_q, sh_q;
  logic [BCD_W-1:0] acc_q, adj, bcd_q;
  logic [BIT_W-1:0] bit_q;

  // Display source selection and add-3 correction of the BCD accumulator.
  always_comb begin
    case (disp_sel)
      2'b00:   val_sel = fare_q;
      2'b01:   val_sel = dist_q;
      2'b10:   val_sel = wait_q;
      default: val_sel = CNT_W'(price_q) * CNT_W'(10);
    endcase
    adj = acc_q;
    for (int unsigned i = 0; i < DIGITS; i++)
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
  end

  // Sequential double-dabble; a changed source restarts the pass so the
  // BCD register never lags a new value by more than one full conversion.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      lat_q <= '0;
      sh_q  <= '0;
      acc_q <= '0;
      bit_q <= '0;
      bcd_q <= '0;
    end else if (val_sel != lat_q) begin
      lat_q <= val_sel;
      sh_q  <= val_sel;
      acc_q <= '0;
      bit_q <= '0;
    end else if (bit_q != BIT_W'(CNT_W)) begin
      acc_q <= {adj[BCD_W-2:0], sh_q[CNT_W-1]};
      sh_q  <= {sh_q[CNT_W-2:0], 1'b0};
      bit_q <= bit_q + 1'b1;
    end else begin
      bcd_q <= (64'(lat_q) > DISP_MAX) ? NINES : acc_q;
      sh_q  <= lat_q;
      acc_q <= '0;
      bit_q <= '0;
    end
  end

  logic [SCAN_W-1:0] scan_cnt_q;
  logic [DIG_W-1:0]  dig_q, dig_d;
  logic [DIGITS-1:0] blank, sm_wei_q;
  logic [7:0]        sm_duan_q;
  logic [3:0]        cur_digit;
  logic              nz;

  // Next scanned digit and leading-zero blanking mask (digit0 always shown).
  always_comb begin
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1))
      dig_d = (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
    else
      dig_d = dig_q;
    blank = '0;
    nz    = 1'b0;
    for (int unsigned k = 0; k < DIGITS - 1; k++) begin
      nz                 = nz | (bcd_q[4*(DIGITS-1-k) +: 4] != 4'd0);
      blank[DIGITS-1-k]  = ~nz;
    end
    cur_digit = bcd_q[4*dig_d +: 4];
  end

  // Display scan: digit select and segment pattern registered together.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      scan_cnt_q <= '0;
      dig_q      <= '0;
      sm_wei_q   <= ~DIGITS'(1);
      sm_duan_q  <= 8'hC0;
    end else begin
      scan_cnt_q <= (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) ? '0 : scan_cnt_q + 1'b1;
      dig_q      <= dig_d;
      sm_wei_q   <= ~(DIGITS'(1) << dig_d);
      sm_duan_q  <= blank[dig_d] ? 8'hFF : seg7(cur_digit);
    end
  end

  assign fare         = fare_q;
  assign state_o      = state_q;
  assign tick_o       = tick_q;
  assign power_on     = (state_q == RUN) || (state_q == PAUSE);
  assign pricing_mode = (state_q == CONFIG);
  assign sm_wei       = sm_wei_q;
  assign sm_duan      = sm_duan_q;

endmodule

// File: tb/tb_taxi_fare_core.sv
// Directed bench for taxi_fare_core: default-width instance plus a narrow
// (CNT_W=8, DIGITS=2) instance for saturation and display overflow.
module tb_taxi_fare_core;

  logic        clk = 1'b0;
  logic        rst, start, pause, leap, cfg_req;
  logic [3:0]  speed, cfg_price;
  logic [1:0]  disp_sel;
  logic [16:0] fare;
  logic [1:0]  state_o;
  logic        tick_o, power_on, pricing_mode;
  logic [4:0]  sm_wei;
  logic [7:0]  sm_duan;

  logic        s_rst, s_start, s_pause, s_leap, s_cfg_req;
  logic [3:0]  s_speed, s_cfg_price;
  logic [1:0]  s_disp_sel;
  logic [7:0]  s_fare;
  logic [1:0]  s_state;
  logic        s_tick, s_power, s_pricing;
  logic [1:0]  s_wei;
  logic [7:0]  s_duan;

  int checks = 0;
  int failures = 0;
  logic [7:0] cap [5];

  always #5 clk = ~clk;

  taxi_fare_core #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
    .clk_50MHz(clk), .rst(rst), .start(start), .pause(pause), .leap(leap),
    .speed(speed), .cfg_req(cfg_req), .cfg_price(cfg_price), .disp_sel(disp_sel),
    .fare(fare), .state_o(state_o), .tick_o(tick_o), .power_on(power_on),
    .pricing_mode(pricing_mode), .sm_wei(sm_wei), .sm_duan(sm_duan));

  taxi_fare_core #(.CNT_W(8), .DIGITS(2), .TICK_DIV(4), .SCAN_DIV(2)) dut8 (
    .clk_50MHz(clk), .rst(s_rst), .start(s_start), .pause(s_pause), .leap(s_leap),
    .speed(s_speed), .cfg_req(s_cfg_req), .cfg_price(s_cfg_price), .disp_sel(s_disp_sel),
    .fare(s_fare), .state_o(s_state), .tick_o(s_tick), .power_on(s_power),
    .pricing_mode(s_pricing), .sm_wei(s_wei), .sm_duan(s_duan));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Count n metering ticks on the chosen instance, then let the fare settle.
  task automatic run_ticks(input int which, input int n);
    int seen = 0;
    int guard = 0;
    while (seen < n && guard < n * 12 + 20) begin
      @(negedge clk);
      guard++;
      if ((which == 0) ? tick_o : s_tick) seen++;
    end
    if (seen < n) chk("tick_timeout", seen, n);
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  // Let the converter settle, then record the segment code of every digit.
  task automatic capture(input int which);
    int nd;
    logic [4:0] w, seen, mask;
    nd = (which == 0) ? 5 : 2;
    seen = '0;
    for (int i = 0; i < 5; i++) cap[i] = 8'h00;
    repeat (30) @(posedge clk);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      w = (which == 0) ? sm_wei : {3'b111, s_wei};
      for (int i = 0; i < nd; i++)
        if (w == ~(5'b00001 << i)) begin
          cap[i]  = (which == 0) ? sm_duan : s_duan;
          seen[i] = 1'b1;
        end
    end
    mask = (5'b00001 << nd) - 5'd1;
    chk("scan_cover", seen, mask);
  endtask

  function automatic int seg2dig(input logic [7:0] s);
    case (s)
      8'hC0: return 0;  8'hF9: return 1;  8'hA4: return 2;  8'hB0: return 3;
      8'h99: return 4;  8'h92: return 5;  8'h82: return 6;  8'hF8: return 7;
      8'h80: return 8;  8'h90: return 9;  8'hFF: return 0;
      default: return 100000;
    endcase
  endfunction

  function automatic int disp_val(input int nd);
    int v = 0;
    int p = 1;
    for (int i = 0; i < nd; i++) begin
      v = v + seg2dig(cap[i]) * p;
      p = p * 10;
    end
    return v;
  endfunction

  task automatic cfg_pulse();
    @(negedge clk) cfg_req = 1'b1;
    @(negedge clk) cfg_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; pause = 1'b0; leap = 1'b0; cfg_req = 1'b0;
    speed = '0; cfg_price = '0; disp_sel = 2'b00;
    s_rst = 1'b1; s_start = 1'b0; s_pause = 1'b0; s_leap = 1'b0; s_cfg_req = 1'b0;
    s_speed = '0; s_cfg_price = '0; s_disp_sel = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_state", state_o, 2'b00);
    chk("rst_fare", fare, 0);
    chk("rst_wei", sm_wei, 5'b11110);
    chk("rst_duan", sm_duan, 8'hC0);
    chk("rst_tick", tick_o, 0);
    chk("rst_power", power_on, 0);

    rst = 1'b0; s_rst = 1'b0;
    c = 0;
    do begin @(negedge clk); c++; end while (!tick_o && c < 20);
    chk("first_tick", c, 4);
    c = 0;
    do begin @(negedge clk); c++; end while (!tick_o && c < 20);
    chk("tick_period", c, 4);

    // Distance metering: speed 3 for 4 ticks.
    start = 1'b1; speed = 4'd3;
    run_ticks(0, 4);
    pause = 1'b1;
    @(negedge clk);
    chk("s1_state_pause", state_o, 2'b10);
    chk("s1_fare", fare, 44);
    capture(0);
    chk("s1_disp_fare", disp_val(5), 44);
    chk("s1_dig0", cap[0], 8'h99);
    chk("s1_dig2_blank", cap[2], 8'hFF);
    chk("s1_dig4_blank", cap[4], 8'hFF);
    disp_sel = 2'b01; capture(0);
    chk("s1_dist", disp_val(5), 12);
    disp_sel = 2'b10; capture(0);
    chk("s1_wait", disp_val(5), 0);
    chk("s1_dig0_zero", cap[0], 8'hC0);

    // Waiting with leap.
    start = 1'b0; pause = 1'b0; speed = 4'd0; leap = 1'b1;
    repeat (3) @(negedge clk);
    chk("s2_idle", state_o, 2'b00);
    chk("s2_idle_fare", fare, 0);
    start = 1'b1;
    run_ticks(0, 3);
    pause = 1'b1;
    @(negedge clk);
    chk("s2_fare_a", fare, 30);
    capture(0);
    chk("s2_wait_a", disp_val(5), 6);
    pause = 1'b0;
    run_ticks(0, 3);
    pause = 1'b1;
    @(negedge clk);
    chk("s2_fare_b", fare, 44);
    capture(0);
    chk("s2_wait_b", disp_val(5), 12);

    // Pause freezes counters, including a tick coinciding with pause.
    start = 1'b0; pause = 1'b0; leap = 1'b0; speed = 4'd2; disp_sel = 2'b01;
    repeat (3) @(negedge clk);
    start = 1'b1;
    run_ticks(0, 1);
    pause = 1'b1;
    run_ticks(0, 5);
    chk("s4_state", state_o, 2'b10);
    chk("s4_power", power_on, 1);
    chk("s4_fare", fare, 30);
    capture(0);
    chk("s4_dist_frozen", disp_val(5), 2);
    pause = 1'b0;
    c = 0;
    do begin @(negedge clk); c++; end while (!tick_o && c < 20);
    pause = 1'b1;
    repeat (3) @(negedge clk);
    chk("s4_same_cycle_state", state_o, 2'b10);
    capture(0);
    chk("s4_same_cycle_dist", disp_val(5), 2);
    start = 1'b0; pause = 1'b0;
    repeat (3) @(negedge clk);
    chk("s4_idle", state_o, 2'b00);
    chk("s4_idle_fare", fare, 0);
    capture(0);
    chk("s4_idle_dist", disp_val(5), 0);

    // Configuration mode.
    cfg_price = 4'd9;
    cfg_pulse();
    chk("cfg_enter", state_o, 2'b11);
    chk("cfg_mode", pricing_mode, 1);
    cfg_pulse();
    chk("cfg_leave", state_o, 2'b00);
    disp_sel = 2'b11; capture(0);
    chk("cfg_price9", disp_val(5), 90);
    cfg_price = 4'd0;
    cfg_pulse(); cfg_pulse();
    capture(0);
    chk("cfg_price0_rej", disp_val(5), 90);
    cfg_pulse();
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("cfg_start_ign", state_o, 2'b11);
    start = 1'b0;
    cfg_pulse();
    chk("cfg_exit2", state_o, 2'b00);

    // Fare with the new price.
    start = 1'b1; speed = 4'd3;
    run_ticks(0, 4);
    pause = 1'b1;
    @(negedge clk);
    chk("p9_fare", fare, 48);

    // Reset in RUN.
    start = 1'b0; pause = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; speed = 4'd10;
    run_ticks(0, 4);
    pause = 1'b1;
    disp_sel = 2'b01; capture(0);
    chk("r_dist40", disp_val(5), 40);
    pause = 1'b0;
    @(negedge clk);
    chk("r_run", state_o, 2'b01);
    rst = 1'b1;
    @(negedge clk);
    chk("r_state", state_o, 2'b00);
    chk("r_fare", fare, 0);
    chk("r_wei", sm_wei, 5'b11110);
    chk("r_duan", sm_duan, 8'hC0);
    chk("r_tick", tick_o, 0);
    start = 1'b0;
    rst = 1'b0;
    disp_sel = 2'b11; capture(0);
    chk("r_price7", disp_val(5), 70);
    disp_sel = 2'b01; capture(0);
    chk("r_dist0", disp_val(5), 0);

    // Narrow instance: saturation and display overflow.
    s_start = 1'b1; s_speed = 4'd15;
    run_ticks(1, 20);
    s_pause = 1'b1;
    @(negedge clk);
    chk("n_fare_sat", s_fare, 255);
    capture(1);
    chk("n_dig0", cap[0], 8'h90);
    chk("n_dig1", cap[1], 8'h90);
    chk("n_disp99", disp_val(2), 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
